// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Sizes depend on module parameters, so they are exposed as constant functions.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic bit split_ok(input int unsigned width,
                                    input int unsigned digit);
        return (digit >= 32'd1) && (digit <= width) && ((width % digit) == 32'd0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple chain of full-adder cells; also exposes the carry into the
// top bit so the caller can form signed overflow on the final digit.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, with a
// registered carry between digits and a start/busy/done handshake.
module serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!split_ok(WIDTH, DIGIT)) begin : g_bad_split
        $error("serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_co;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters at the MSB end; concatenation keeps DIGIT == WIDTH legal.
    assign sum_cat = {dig_s, sum_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_co;
                sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = dig_co;
                    ovf_d   = dig_co ^ dig_cmsb;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub over four WIDTH/DIGIT configurations, using directed
// vectors, handshake corner sequences and random operations against a model.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    int unsigned sel;

    logic st0, st1, st2, st3;
    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);
    assign st3 = start && (sel == 3);

    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic        cout0, cout1, cout2, cout3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic [15:0] sum0, sum1, sum2;
    logic [7:0]  sum3;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(st0), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));
    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(st1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(st2), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));
    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_w8 (
        .clk(clk), .rst(rst), .start(st3), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3));

    logic        busy_m, done_m, cout_m, ovf_m;
    logic [15:0] sum_m;

    always_comb begin
        busy_m = busy0; done_m = done0; cout_m = cout0; ovf_m = ovf0; sum_m = sum0;
        case (sel)
            1: begin busy_m = busy1; done_m = done1; cout_m = cout1; ovf_m = ovf1; sum_m = sum1; end
            2: begin busy_m = busy2; done_m = done2; cout_m = cout2; ovf_m = ovf2; sum_m = sum2; end
            3: begin busy_m = busy3; done_m = done3; cout_m = cout3; ovf_m = ovf3; sum_m = {8'h00, sum3}; end
            default: ;
        endcase
    end

    int unsigned cfg_w [4] = '{16, 16, 16, 8};
    int unsigned cfg_n [4] = '{4, 16, 1, 4};

    int checks = 0;
    int errors = 0;

    logic [15:0] last_sum;
    logic        last_cout, last_ovf;

    typedef struct {
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic [15:0] esum;
        logic        eco;
        logic        eov;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cfg %0d): got %0h want %0h", name, sel, act, exp);
        end
    endtask

    // Reference: operand B is complemented and cin inverted for subtract, then
    // plain modular addition; overflow from true signed arithmetic range.
    function automatic void model(input int unsigned w, input logic s,
                                  input logic [15:0] x, input logic [15:0] y, input logic c,
                                  output logic [15:0] rs, output logic rc, output logic rv);
        longint md, half, xx, yy, c0, tot, sx, sy, st;
        md   = longint'(1) << w;
        half = md / 2;
        xx   = longint'(x) % md;
        yy   = longint'(y) % md;
        if (s) yy = md - 1 - yy;
        c0   = (c ^ s) ? 1 : 0;
        tot  = xx + yy + c0;
        rs   = 16'(tot % md);
        rc   = (tot >= md);
        sx   = (xx >= half) ? xx - md : xx;
        sy   = (yy >= half) ? yy - md : yy;
        st   = sx + sy + c0;
        rv   = (st < -half) || (st >= half);
    endfunction

    // Drives an accept at the next edge; caller must be positioned just after an edge.
    task automatic run_op(input logic s, input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [15:0] es, input logic eco, input logic eov,
                          input bit chain, input bit noise);
        int unsigned n;
        int cyc;
        bit got;
        n = cfg_n[sel];
        sub = s; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", busy_m, 1);
        check("accept_done", done_m, 0);
        start = 1'b0;
        cyc = 0;
        got = 0;
        while (!got && cyc < int'(n) + 8) begin
            if (noise) begin
                start = 1'($urandom_range(1, 0));
                a = 16'($urandom);
                b = 16'($urandom);
                sub = 1'($urandom_range(1, 0));
                cin = 1'($urandom_range(1, 0));
            end
            @(posedge clk); #1;
            cyc++;
            if (done_m) got = 1;
        end
        start = 1'b0;
        check("done_latency", cyc, n);
        check("busy_at_done", busy_m, 0);
        check("sum", sum_m, es);
        check("cout", cout_m, eco);
        check("ovf", ovf_m, eov);
        last_sum = es; last_cout = eco; last_ovf = eov;
        if (!chain) begin
            @(posedge clk); #1;
            check("done_width", done_m, 0);
            check("idle_busy", busy_m, 0);
        end
    endtask

    task automatic run_model(input logic s, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input bit chain, input bit noise);
        logic [15:0] es;
        logic eco, eov;
        model(cfg_w[sel], s, x, y, c, es, eco, eov);
        run_op(s, x, y, c, es, eco, eov, chain, noise);
    endtask

    task automatic hold_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("hold_done", done_m, 0);
            check("hold_sum", sum_m, last_sum);
            check("hold_cout", cout_m, last_cout);
            check("hold_ovf", ovf_m, last_ovf);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b1; sel = 0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;

        // Reset held with start asserted and random operands.
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            sub = 1'($urandom_range(1, 0)); cin = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            check("rst_busy", busy_m, 0);
            check("rst_done", done_m, 0);
            check("rst_sum", sum_m, 0);
            check("rst_cout", cout_m, 0);
            check("rst_ovf", ovf_m, 0);
        end
        rst = 1'b0;

        // Directed vectors on every configuration.
        for (int d = 0; d < 4; d++) begin
            sel = d;
            for (int i = 0; i < 7; i++) begin
                if (cfg_w[d] == 16)
                    run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].c,
                           vecs[i].esum, vecs[i].eco, vecs[i].eov, 0, 0);
                else
                    run_model(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].c, 0, 0);
                if (d == 0 && i == 0) hold_check(5);
            end
        end

        // Start pulses and operand churn while busy must not disturb the result.
        sel = 0;
        run_model(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 0, 1);
        hold_check(2);

        // Back-to-back accept in the DONE cycle.
        for (int d = 0; d < 4; d++) begin
            sel = d;
            run_model(1'b0, 16'h1111, 16'h2222, 1'b0, 1, 0);
            run_model(1'b1, 16'h0100, 16'h0003, 1'b0, 1, 0);
            run_model(1'b0, 16'hABCD, 16'h5432, 1'b1, 0, 0);
        end

        // Reset after two digits aborts the operation.
        sel = 0;
        sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy_m, 0);
        check("abort_done", done_m, 0);
        check("abort_sum", sum_m, 0);
        check("abort_cout", cout_m, 0);
        check("abort_ovf", ovf_m, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done_m, 0);
        end
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);

        // Random operations on every configuration.
        for (int d = 0; d < 4; d++) begin
            sel = d;
            for (int i = 0; i < 25; i++)
                run_model(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(1, 0)), bit'($urandom_range(1, 0)),
                          bit'($urandom_range(1, 0)));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock from LSB to MSB, using a registered carry between digits. A start/busy/done handshake frames each operation, and results are held until the next operation is accepted. It is the area-lean arithmetic element for datapaths where a full WIDTH-bit ripple chain is too costly or too slow for the clock.

Parameters:
WIDTH, 16, operand/result width in bits
DIGIT, 4, bits processed per cycle; must divide WIDTH (1 ≤ DIGIT ≤ WIDTH); N = WIDTH/DIGIT cycles per operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when not busy
sub  in  1  0 = add, 1 = subtract; latched on accept
a  in  WIDTH  operand A; latched on accept
b  in  WIDTH  operand B; latched on accept
cin  in  1  carry-in; latched on accept
busy  out  1  operation in progress
done  out  1  one-cycle pulse; results valid
sum  out  WIDTH  result
cout  out  1  final carry-out (for subtract: 1 = no borrow)
ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; digit counter=0; internal carry=0.
- Reset is synchronous and dominates all other inputs, including mid-operation.
- Reset mid-operation aborts the operation. The next cycle is IDLE with outputs cleared. No done is produced for the aborted operation.
- States are IDLE, RUN and DONE.
- IDLE, start=1 at edge k:
  - Latch a, b^{WIDTH{sub}}, and carry = cin^sub.
  - Clear the counter and go to RUN; busy=1 from edge k.
- RUN: at each edge, the combinational DIGIT-bit chain adds the current operand digits plus the carry register.
  - The digit result shifts into sum from the MSB end; operands shift right by DIGIT; the carry register updates.
  - The counter increments, wrapping at N-1.
  - Edges k+1 … k+N process digits 0 … N-1.
- At edge k+N (last digit):
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB. The carry into the MSB is captured within the last digit; when DIGIT=1 it is the carry register value.
  - busy=0, done=1, state DONE.
  - Latency from accept edge to done high is exactly N cycles.
- DONE: done is high for exactly one cycle. sum/cout/ovf are held stable until the next accept or reset.
  - start=1 in DONE is accepted (back-to-back, identical to the IDLE accept): busy=1 and done=0 next cycle.
  - Otherwise the state goes to IDLE.
- start while busy is ignored. Operand/sub/cin changes after accept have no effect.
- sum is updated only in RUN. Intermediate partial values during busy are not valid and must not be relied on.
- Subtract semantics: sub=1, cin=0 gives a−b; sub=1, cin=1 gives a−b+1. cout=0 signals a borrow.
- All arithmetic is modulo 2^WIDTH. No saturation.

Decomposition:
- Shared package arith_pkg holds:
  - The state enum type (IDLE/RUN/DONE).
  - The localparam N = WIDTH/DIGIT.
  - The counter width $clog2(N) (minimum 1).
  - An elaboration check that WIDTH % DIGIT == 0.
- One sub-module, digit_adder, parametrised by DIGIT:
  - Inputs x[DIGIT], y[DIGIT], ci.
  - Outputs s[DIGIT], co, and c_msb (carry into the top bit).
  - Structural chain of full-adder cells.
- The FSM, counter and shift registers live in serial_addsub.

Test Plan:
1. rst held 3 cycles with random inputs and start=1 -> busy=0, done=0, sum=0x0000, cout=0, ovf=0 throughout; first start after rst release accepted.
2. WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, sub=0, cin=0 -> done high exactly 4 cycles after accept edge, 1 cycle wide; sum=0x5555, cout=0, ovf=0; results held 5 further idle cycles.
3. Carry across all digit boundaries:
   - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
   - 0x0FFF+0x0000 with cin=1 -> sum=0x1000.
4. Subtract:
   - 0x0005−0x0007 -> sum=0xFFFE, cout=0, ovf=0.
   - 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovf=1.
   - 0x1234−0x1234 -> sum=0x0000, cout=1.
5. Handshake:
   - start pulses and operand changes during busy -> ignored, result unchanged.
   - start asserted in the DONE cycle -> new operation accepted, next done 4 cycles later, no idle gap.
6. Reset mid-operation and parameter sweep:
   - rst asserted after 2 digits -> no done, outputs zero next cycle; following 0x00FF+0x0001 -> sum=0x0100.
   - Repeat scenarios 2–4 with DIGIT=1 (latency 16), DIGIT=16 (latency 1) and WIDTH=8/DIGIT=2; results must match the reference model.
